// File: rtl/reg_read_unit.sv
// Register file read side: 16 registers, one-hot write wordline, two registered read ports.
// Optional macro REG_BYPASS_EN forwards same-cycle write data to a matching read port.
module reg_read_unit #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned ZERO_R0 = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      Wordline,
  input  logic [WIDTH-1:0] WriteData,
  input  logic [3:0]       SrcReg1,
  input  logic [3:0]       SrcReg2,
  input  logic             ReadEn,
  output logic [WIDTH-1:0] SrcData1,
  output logic [WIDTH-1:0] SrcData2,
  output logic             ReadValid,
  output logic             WrErr
);

  localparam int unsigned NREGS = 16;

  logic [WIDTH-1:0] regs [NREGS];
  logic             wl_any;
  logic             wl_multi;
  logic [NREGS-1:0] wr_en;
  logic [NREGS-1:0] rd_sel1;
  logic [NREGS-1:0] rd_sel2;
  logic [WIDTH-1:0] rd_data1_c;
  logic [WIDTH-1:0] rd_data2_c;

  // Legal writes are exactly one-hot; R0 writes are dropped when it is hardwired to zero.
  always_comb begin
    wl_any   = |Wordline;
    wl_multi = |(Wordline & (Wordline - 16'd1));
    wr_en    = (wl_any && !wl_multi) ? Wordline : '0;
    if (ZERO_R0 != 0) begin
      wr_en[0] = 1'b0;
    end
  end

  // 4-to-16 read decoders feeding AND-OR read muxes.
  always_comb begin
    rd_sel1    = NREGS'(1) << SrcReg1;
    rd_sel2    = NREGS'(1) << SrcReg2;
    rd_data1_c = '0;
    rd_data2_c = '0;
    for (int i = 0; i < NREGS; i++) begin
      if ((ZERO_R0 == 0) || (i != 0)) begin
        rd_data1_c = rd_data1_c | ({WIDTH{rd_sel1[i]}} & regs[i]);
        rd_data2_c = rd_data2_c | ({WIDTH{rd_sel2[i]}} & regs[i]);
      end
    end
`ifdef REG_BYPASS_EN
    if (|(rd_sel1 & wr_en)) begin
      rd_data1_c = WriteData;
    end
    if (|(rd_sel2 & wr_en)) begin
      rd_data2_c = WriteData;
    end
`endif
  end

  // Storage array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wr_en[i]) begin
          regs[i] <= WriteData;
        end
      end
    end
  end

  // Registered read outputs and sticky wordline error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      SrcData1  <= '0;
      SrcData2  <= '0;
      ReadValid <= 1'b0;
      WrErr     <= 1'b0;
    end else begin
      ReadValid <= ReadEn;
      if (ReadEn) begin
        SrcData1 <= rd_data1_c;
        SrcData2 <= rd_data2_c;
      end
      if (wl_multi) begin
        WrErr <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reg_read_unit.sv
// Directed table-driven bench for reg_read_unit, plus async-reset corner sequences.
module tb_reg_read_unit;

  localparam int unsigned WIDTH   = 16;
  localparam int unsigned ZERO_R0 = 1;
`ifdef REG_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam logic [15:0] R0V = (ZERO_R0 != 0) ? 16'h0000 : 16'h1234;

  logic             clk;
  logic             rst_n;
  logic [15:0]      wordline;
  logic [WIDTH-1:0] write_data;
  logic [3:0]       src_reg1;
  logic [3:0]       src_reg2;
  logic             read_en;
  logic [WIDTH-1:0] src_data1;
  logic [WIDTH-1:0] src_data2;
  logic             read_valid;
  logic             wr_err;

  reg_read_unit #(.WIDTH(WIDTH), .ZERO_R0(ZERO_R0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Wordline  (wordline),
    .WriteData (write_data),
    .SrcReg1   (src_reg1),
    .SrcReg2   (src_reg2),
    .ReadEn    (read_en),
    .SrcData1  (src_data1),
    .SrcData2  (src_data2),
    .ReadValid (read_valid),
    .WrErr     (wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] wl;
    logic [15:0] wd;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic        re;
    logic [15:0] d1;
    logic [15:0] d2;
    logic        rv;
    logic        err;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];
  int   n_cmp;
  int   n_miss;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] d1, input logic [15:0] d2,
                           input logic rv, input logic err);
    check({tag, ".d1"}, 32'(src_data1), 32'(d1));
    check({tag, ".d2"}, 32'(src_data2), 32'(d2));
    check({tag, ".rv"}, 32'(read_valid), 32'(rv));
    check({tag, ".err"}, 32'(wr_err), 32'(err));
  endtask

  initial begin
    n_cmp  = 0;
    n_miss = 0;
    //             wl        wd        s1     s2     re    d1                         d2        rv    err
    vecs[0]  = '{16'h0000, 16'h0000, 4'd3,  4'd15, 1'b1, 16'h0000,                 16'h0000, 1'b1, 1'b0};
    vecs[1]  = '{16'h0020, 16'hBEEF, 4'd5,  4'd5,  1'b0, 16'h0000,                 16'h0000, 1'b0, 1'b0};
    vecs[2]  = '{16'h0000, 16'h0000, 4'd5,  4'd5,  1'b1, 16'hBEEF,                 16'hBEEF, 1'b1, 1'b0};
    vecs[3]  = '{16'h0000, 16'h0000, 4'd1,  4'd2,  1'b0, 16'hBEEF,                 16'hBEEF, 1'b0, 1'b0};
    vecs[4]  = '{16'h0000, 16'h0000, 4'd1,  4'd2,  1'b0, 16'hBEEF,                 16'hBEEF, 1'b0, 1'b0};
    vecs[5]  = '{16'h0000, 16'h0000, 4'd1,  4'd2,  1'b0, 16'hBEEF,                 16'hBEEF, 1'b0, 1'b0};
    vecs[6]  = '{16'h0001, 16'h1234, 4'd0,  4'd5,  1'b0, 16'hBEEF,                 16'hBEEF, 1'b0, 1'b0};
    vecs[7]  = '{16'h0000, 16'h0000, 4'd0,  4'd5,  1'b1, R0V,                      16'hBEEF, 1'b1, 1'b0};
    vecs[8]  = '{16'h0080, 16'h00AA, 4'd5,  4'd0,  1'b1, 16'hBEEF,                 R0V,      1'b1, 1'b0};
    vecs[9]  = '{16'h0080, 16'h5555, 4'd7,  4'd7,  1'b1, BYP ? 16'h5555 : 16'h00AA,
                 BYP ? 16'h5555 : 16'h00AA, 1'b1, 1'b0};
    vecs[10] = '{16'h0000, 16'h0000, 4'd7,  4'd3,  1'b1, 16'h5555,                 16'h0000, 1'b1, 1'b0};
    vecs[11] = '{16'h0008, 16'h1111, 4'd5,  4'd7,  1'b1, 16'hBEEF,                 16'h5555, 1'b1, 1'b0};
    vecs[12] = '{16'h0000, 16'h0000, 4'd3,  4'd3,  1'b1, 16'h1111,                 16'h1111, 1'b1, 1'b0};
    vecs[13] = '{16'h0003, 16'hFFFF, 4'd0,  4'd1,  1'b1, R0V,                      16'h0000, 1'b1, 1'b1};
    vecs[14] = '{16'h0000, 16'h0000, 4'd0,  4'd1,  1'b1, R0V,                      16'h0000, 1'b1, 1'b1};
    vecs[15] = '{16'h0002, 16'h2222, 4'd1,  4'd3,  1'b1, BYP ? 16'h2222 : 16'h0000, 16'h1111, 1'b1, 1'b1};
    vecs[16] = '{16'h0000, 16'h0000, 4'd1,  4'd0,  1'b1, 16'h2222,                 R0V,      1'b1, 1'b1};
    vecs[17] = '{16'h0001, 16'hABCD, 4'd0,  4'd1,  1'b1,
                 (ZERO_R0 != 0) ? 16'h0000 : (BYP ? 16'hABCD : 16'h1234), 16'h2222, 1'b1, 1'b1};

    rst_n      = 1'b0;
    wordline   = '0;
    write_data = '0;
    src_reg1   = '0;
    src_reg2   = '0;
    read_en    = 1'b0;
    @(posedge clk);
    #1;
    check_all("reset", 16'h0, 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      wordline   = vecs[i].wl;
      write_data = vecs[i].wd;
      src_reg1   = vecs[i].s1;
      src_reg2   = vecs[i].s2;
      read_en    = vecs[i].re;
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].d1, vecs[i].d2, vecs[i].rv, vecs[i].err);
    end

    // Async reset while a read is pending: outputs clear before the next edge.
    wordline = '0;
    src_reg1 = 4'd5;
    src_reg2 = 4'd3;
    read_en  = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 16'h0, 16'h0, 1'b0, 1'b0);
    read_en = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("no_resume", 16'h0, 16'h0, 1'b0, 1'b0);

    // Registers were cleared by reset.
    read_en = 1'b1;
    @(posedge clk);
    #1;
    check_all("post_rst_rd", 16'h0, 16'h0, 1'b1, 1'b0);

    // Same-register dual read after a fresh write.
    wordline   = 16'h8000;
    write_data = 16'hC3C3;
    read_en    = 1'b0;
    @(posedge clk);
    #1;
    wordline = '0;
    src_reg1 = 4'd15;
    src_reg2 = 4'd15;
    read_en  = 1'b1;
    @(posedge clk);
    #1;
    check_all("r15_dual", 16'hC3C3, 16'hC3C3, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end

endmodule

// File: doc/reg_read_unit.md
Name: reg_read_unit

Overview:
- Read side of the register file: 16 storage registers plus two synchronous read ports.
- The write side arrives as a one-hot 16-bit wordline from the write decoder, with its data word.
- Each read port decodes a 4-bit register ID and returns a registered data word one cycle later.
- Sits between the decode stage (register IDs) and the execute-stage operand latches.

Parameters:
- WIDTH, 16, data width of each register and of every data port.
- ZERO_R0, 1, when 1 register 0 reads as all-zeros and ignores writes; when 0 it is an ordinary register.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- Wordline  input  16  one-hot write select from the write decoder; all-zero means no write.
- WriteData  input  WIDTH  data written to the selected register.
- SrcReg1  input  4  read port 1 register ID.
- SrcReg2  input  4  read port 2 register ID.
- ReadEn  input  1  read request for both ports this cycle.
- SrcData1  output  WIDTH  registered read data, port 1.
- SrcData2  output  WIDTH  registered read data, port 2.
- ReadValid  output  1  high for one cycle when SrcData1/2 carry the result of a request.
- WrErr  output  1  sticky flag: a non-one-hot, non-zero Wordline was seen.

Behaviour:
- One clock domain. Reset is asynchronous and active-low. Clock and reset ports are named clk and rst_n.
- Reset (rst_n low, asynchronous):
  - all 16 registers go to 0;
  - SrcData1, SrcData2, ReadValid and WrErr go to 0.
- Write, at rising edge:
  - exactly one Wordline bit i set: register i <= WriteData;
  - Wordline all-zero: no change;
  - two or more bits set: no register changes and WrErr <= 1. WrErr stays 1 until reset.
  - With ZERO_R0=1, a write to register 0 is silently dropped. It is not an error.
- Read, at rising edge with ReadEn=1:
  - SrcDataN <= contents of register SrcRegN, decoded internally by a 4-to-16 read decoder;
  - ReadValid <= 1.
- Read, at rising edge with ReadEn=0:
  - SrcData1 and SrcData2 hold their previous values;
  - ReadValid <= 0.
- Read latency: one cycle from request to ReadValid.
- ZERO_R0=1: a read of register 0 always returns 0.
- Both ports may address the same register in the same cycle; both return the same value.
- Write and read of the same register in the same cycle: the result depends on the optional feature below.
- A read of register i is never affected by a write to any other register j in the same cycle.
- rst_n asserted while a read is pending: ReadValid is cleared and the pending data is lost. No read resumes after reset.

Optional Feature:
- Macro: REG_BYPASS_EN.
- Defined: write-to-read forwarding. When ReadEn=1 and Wordline is one-hot selecting register SrcRegN (and that register is not a dropped R0 write), SrcDataN <= WriteData. The stored register also updates.
- Not defined: a same-cycle read returns the pre-write contents. The new value becomes visible to reads issued from the next cycle on.

Test Plan:
- Reset then read: rst_n low, then high; ReadEn=1, SrcReg1=3, SrcReg2=15 -> next cycle SrcData1=0, SrcData2=0, ReadValid=1, WrErr=0.
- Write then read: Wordline=16'h0020, WriteData=16'hBEEF; next cycle ReadEn=1, SrcReg1=5, SrcReg2=5 -> one cycle later both SrcData=16'hBEEF, ReadValid=1.
- Hold and R0: ReadEn=0 for 3 cycles -> SrcData unchanged, ReadValid=0. Then write 16'h1234 with Wordline=16'h0001 and read SrcReg1=0 -> with ZERO_R0=1 SrcData1=0; with ZERO_R0=0 SrcData1=16'h1234.
- Same-cycle write/read of reg 7: register 7 holds 16'h00AA; Wordline=16'h0080, WriteData=16'h5555, ReadEn=1, SrcReg1=7 -> SrcData1=16'h5555 with REG_BYPASS_EN defined, 16'h00AA without. A read of reg 7 in the following cycle returns 16'h5555 in both builds.
- Illegal wordline: Wordline=16'h0003, WriteData=16'hFFFF -> registers 0 and 1 unchanged, WrErr=1 from the next cycle and stays 1. Asserting rst_n clears it.
- Async reset mid-read: ReadEn=1, then rst_n pulsed low between clock edges -> SrcData1, SrcData2 and ReadValid drop to 0 immediately, before the next rising edge.
